rvv_backend_retire_vd_merge: RTL and testbench
==============================================

Name: rvv_backend_retire_vd_merge

Overview:
Retire-side consumer of the per-byte operand types that dispatch attaches to each uop (BODY_ACTIVE, BODY_INACTIVE, TAIL, NOT_CHANGE).
It takes one retiring uop result plus its vd byte types and mask/tail policy, and builds a full-register VRF write.
The VRF write port has no byte strobe. When any byte must stay undisturbed, the block reads the old vd first (read-modify-write).
It sits between the ROB retire output and the VRF write port, with one uop in flight.

Parameters:
AGNOSTIC_ONES, 1, 1: agnostic bytes are written 0xFF; 0: agnostic bytes keep their old value, which forces a read.
VLEN / VLENB come from the `VLEN / `VLENB macros (defaults 128 / 16); they are not module parameters.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
rob_valid  in  1  retiring uop valid
rob_ready  out  1  block can accept a uop
rob_vd_index  in  5  destination register
rob_vd_data  in  VLEN  result data
rob_vd_byte_type  in  VLENB x BYTE_TYPE_t  per-byte type from dispatch
rob_vta  in  1  tail agnostic
rob_vma  in  1  mask agnostic
rob_trap_flush  in  1  abort uncommitted merge
vrf_rd_req  out  1  old-vd read request
vrf_rd_addr  out  5  read register
vrf_rd_data  in  VLEN  old vd, valid exactly 1 cycle after vrf_rd_req
vrf_wr_valid  out  1  write valid
vrf_wr_ready  in  1  write accepted
vrf_wr_addr  out  5  write register
vrf_wr_data  out  VLEN  merged data
busy  out  1  state != IDLE

Behaviour:
- Reset values: state=IDLE; rob_ready=1; vrf_rd_req=0; vrf_wr_valid=0; vrf_rd_addr, vrf_wr_addr and vrf_wr_data all 0; busy=0.
- Byte classification at accept, one class per byte:
  - NEW: BODY_ACTIVE.
  - AGN: TAIL with vta=1, or BODY_INACTIVE with vma=1.
  - KEEP: NOT_CHANGE, TAIL with vta=0, or BODY_INACTIVE with vma=0.
  - AGN bytes are reclassified as KEEP when AGNOSTIC_ONES=0.
  - need_old = OR over bytes of KEEP. all_keep = AND over bytes of KEEP.
- Merge per byte:
  - NEW takes rob_vd_data.
  - AGN takes 8'hFF.
  - KEEP takes captured vrf_rd_data.
- FSM has four states: IDLE, RD_OLD, WAIT_OLD, WRITE.
- IDLE:
  - rob_ready=1.
  - On rob_valid, capture the uop into the holding register.
  - all_keep goes to IDLE; nothing is read or written, and the uop is dropped.
  - Otherwise need_old goes to RD_OLD, else to WRITE.
- RD_OLD: vrf_rd_req=1 for exactly one cycle, vrf_rd_addr=vd index; go to WAIT_OLD.
- WAIT_OLD: sample vrf_rd_data, register the merged data, go to WRITE.
- WRITE:
  - vrf_wr_valid=1; vrf_wr_addr and vrf_wr_data are held stable until vrf_wr_ready.
  - On the handshake, go to IDLE.
  - rob_ready=0 in every state except IDLE.
- Latency, with accept at cycle T:
  - No read: vrf_wr_valid at T+1.
  - Read: vrf_rd_req at T+1, data sampled at T+2, vrf_wr_valid at T+3.
  - Back-to-back accept is possible in the cycle after the write handshake.
- Only one uop is in flight, so a read always observes the previous write. No bypass is needed.
- rob_trap_flush:
  - In RD_OLD or WAIT_OLD: go to IDLE with no write.
  - In WRITE: ignored; the write completes.
  - In IDLE: blocks accept that cycle.
  - Flush has priority over every other transition.
- Reset mid-operation returns to IDLE immediately; a pending write is lost and vrf_wr_valid drops asynchronously.

Decomposition:
- BYTE_TYPE_t already exists in rvv_backend.svh.
- Add RETIRE_MERGE_STATE_e (IDLE, RD_OLD, WAIT_OLD, WRITE) to the same package.
- One natural sub-module, rvv_backend_retire_byte_merge: purely combinational per-byte classification and merge. It outputs need_old, all_keep and the merged data.

Test Plan:
1. All 16 bytes BODY_ACTIVE, data bytes 0x00..0x0F, vd=3 -> no vrf_rd_req; vrf_wr_valid at T+1, addr=3, data equals input.
2. Bytes 0-7 BODY_ACTIVE (0x11), bytes 8-15 TAIL, vta=1, AGNOSTIC_ONES=1 -> no read; data low 8 bytes 0x11, high 8 bytes 0xFF.
3. Same as 2 but vta=0, vd=5, vrf_rd_data all 0xAA -> vrf_rd_req at T+1 with addr 5; vrf_wr_valid at T+3; high bytes 0xAA, low bytes 0x11.
4. All NOT_CHANGE -> no read, no write; rob_ready=1 again at T+1.
5. Case 1 with vrf_wr_ready low for 3 cycles -> vrf_wr_valid, addr and data stable; rob_ready=0 until the handshake, then 1.
6. Case 3 with rob_trap_flush in WAIT_OLD -> no vrf_wr_valid, IDLE next cycle. Separately, rst_n low during WRITE -> all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/rvv_backend_retire_vd_merge_pkg.sv
// Shared types for the retire-side vd merge: per-byte operand types, merge FSM states
// and the byte classification rule used when a uop is accepted.
`ifndef VLEN
`define VLEN 128
`endif
`ifndef VLENB
`define VLENB (`VLEN/8)
`endif

package rvv_backend_retire_vd_merge_pkg;

    localparam int VLEN  = `VLEN;
    localparam int VLENB = `VLENB;

    typedef enum logic [1:0] {
        BODY_ACTIVE   = 2'd0,
        BODY_INACTIVE = 2'd1,
        TAIL          = 2'd2,
        NOT_CHANGE    = 2'd3
    } BYTE_TYPE_t;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RD_OLD   = 2'd1,
        WAIT_OLD = 2'd2,
        WRITE    = 2'd3
    } RETIRE_MERGE_STATE_e;

    typedef enum logic [1:0] {
        CLS_NEW  = 2'd0,
        CLS_AGN  = 2'd1,
        CLS_KEEP = 2'd2
    } byte_class_e;

    // Without the all-ones policy an agnostic byte must be preserved, so it needs the old value.
    function automatic byte_class_e classify_byte(input logic [1:0] byte_type,
                                                  input logic       vta,
                                                  input logic       vma,
                                                  input logic       agnostic_ones);
        byte_class_e cls;
        case (BYTE_TYPE_t'(byte_type))
            BODY_ACTIVE:   cls = CLS_NEW;
            BODY_INACTIVE: cls = vma ? CLS_AGN : CLS_KEEP;
            TAIL:          cls = vta ? CLS_AGN : CLS_KEEP;
            default:       cls = CLS_KEEP;
        endcase
        if (cls == CLS_AGN && !agnostic_ones) begin
            cls = CLS_KEEP;
        end
        return cls;
    endfunction

endpackage

// File: rtl/rvv_backend_retire_byte_merge.sv
// Combinational per-byte classification and merge of new result, agnostic fill and old vd.
module rvv_backend_retire_byte_merge
    import rvv_backend_retire_vd_merge_pkg::*;
#(
    parameter logic AGNOSTIC_ONES = 1'b1
)
(
    input  logic [2*VLENB-1:0] byte_type,
    input  logic               vta,
    input  logic               vma,
    input  logic [VLEN-1:0]    new_data,
    input  logic [VLEN-1:0]    old_data,
    output logic               need_old,
    output logic               all_keep,
    output logic [VLEN-1:0]    merged_data
);

    always_comb begin
        need_old    = 1'b0;
        all_keep    = 1'b1;
        merged_data = '0;
        for (int i = 0; i < VLENB; i++) begin
            case (classify_byte(byte_type[2*i +: 2], vta, vma, AGNOSTIC_ONES))
                CLS_NEW: begin
                    merged_data[8*i +: 8] = new_data[8*i +: 8];
                    all_keep              = 1'b0;
                end
                CLS_AGN: begin
                    merged_data[8*i +: 8] = 8'hFF;
                    all_keep              = 1'b0;
                end
                default: begin
                    merged_data[8*i +: 8] = old_data[8*i +: 8];
                    need_old              = 1'b1;
                end
            endcase
        end
    end

endmodule

// File: rtl/rvv_backend_retire_vd_merge.sv
// Retire-side vd writer: turns one retiring uop plus its byte types into a full-register
// VRF write, reading the old vd first whenever some byte must stay undisturbed.
//
// state    | meaning
// IDLE     | ready for a uop; an all-keep uop is dropped here
// RD_OLD   | old vd read request issued this cycle
// WAIT_OLD | old vd returned; merged data registered
// WRITE    | full-register write held until vrf_wr_ready
module rvv_backend_retire_vd_merge
    import rvv_backend_retire_vd_merge_pkg::*;
#(
    parameter logic AGNOSTIC_ONES = 1'b1
)
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               rob_valid,
    output logic               rob_ready,
    input  logic [4:0]         rob_vd_index,
    input  logic [VLEN-1:0]    rob_vd_data,
    input  logic [2*VLENB-1:0] rob_vd_byte_type,
    input  logic               rob_vta,
    input  logic               rob_vma,
    input  logic               rob_trap_flush,
    output logic               vrf_rd_req,
    output logic [4:0]         vrf_rd_addr,
    input  logic [VLEN-1:0]    vrf_rd_data,
    output logic               vrf_wr_valid,
    input  logic               vrf_wr_ready,
    output logic [4:0]         vrf_wr_addr,
    output logic [VLEN-1:0]    vrf_wr_data,
    output logic               busy
);

    RETIRE_MERGE_STATE_e state_q, state_d;

    logic [4:0]         hold_vd_q;
    logic [VLEN-1:0]    hold_data_q;
    logic [2*VLENB-1:0] hold_type_q;
    logic               hold_vta_q;
    logic               hold_vma_q;
    logic [VLEN-1:0]    wr_data_q;

    logic               in_idle;
    logic               accept;
    logic [2*VLENB-1:0] bm_type;
    logic               bm_vta;
    logic               bm_vma;
    logic [VLEN-1:0]    bm_new;
    logic               need_old;
    logic               all_keep;
    logic [VLEN-1:0]    merged_data;

    assign in_idle = (state_q == IDLE);
    assign accept  = in_idle && rob_valid && !rob_trap_flush;

    // One merge instance: fed live from the ROB while idle, from the holding register afterwards.
    assign bm_type = in_idle ? rob_vd_byte_type : hold_type_q;
    assign bm_vta  = in_idle ? rob_vta          : hold_vta_q;
    assign bm_vma  = in_idle ? rob_vma          : hold_vma_q;
    assign bm_new  = in_idle ? rob_vd_data      : hold_data_q;

    rvv_backend_retire_byte_merge #(
        .AGNOSTIC_ONES (AGNOSTIC_ONES)
    ) u_byte_merge (
        .byte_type   (bm_type),
        .vta         (bm_vta),
        .vma         (bm_vma),
        .new_data    (bm_new),
        .old_data    (vrf_rd_data),
        .need_old    (need_old),
        .all_keep    (all_keep),
        .merged_data (merged_data)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (all_keep) begin
                        state_d = IDLE;
                    end else if (need_old) begin
                        state_d = RD_OLD;
                    end else begin
                        state_d = WRITE;
                    end
                end
            end
            RD_OLD:   state_d = rob_trap_flush ? IDLE : WAIT_OLD;
            WAIT_OLD: state_d = rob_trap_flush ? IDLE : WRITE;
            WRITE: begin
                if (vrf_wr_ready) begin
                    state_d = IDLE;
                end
            end
            default:  state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            hold_vd_q   <= '0;
            hold_data_q <= '0;
            hold_type_q <= '0;
            hold_vta_q  <= 1'b0;
            hold_vma_q  <= 1'b0;
            wr_data_q   <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                hold_vd_q   <= rob_vd_index;
                hold_data_q <= rob_vd_data;
                hold_type_q <= rob_vd_byte_type;
                hold_vta_q  <= rob_vta;
                hold_vma_q  <= rob_vma;
                // Final for no-read uops; overwritten in WAIT_OLD when the old vd is needed.
                wr_data_q   <= merged_data;
            end
            if (state_q == WAIT_OLD) begin
                wr_data_q <= merged_data;
            end
        end
    end

    assign rob_ready    = in_idle && !rob_trap_flush;
    assign vrf_rd_req   = (state_q == RD_OLD);
    assign vrf_rd_addr  = hold_vd_q;
    assign vrf_wr_valid = (state_q == WRITE);
    assign vrf_wr_addr  = hold_vd_q;
    assign vrf_wr_data  = wr_data_q;
    assign busy         = !in_idle;

endmodule

// File: tb/tb_rvv_backend_retire_vd_merge.sv
// Randomized bench for the retire vd merge against a byte-level model and a VRF memory model.
module tb_rvv_backend_retire_vd_merge;
    import rvv_backend_retire_vd_merge_pkg::*;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               rob_valid = 1'b0;
    logic               rob_ready;
    logic [4:0]         rob_vd_index = '0;
    logic [VLEN-1:0]    rob_vd_data = '0;
    logic [2*VLENB-1:0] rob_vd_byte_type = '0;
    logic               rob_vta = 1'b0;
    logic               rob_vma = 1'b0;
    logic               rob_trap_flush = 1'b0;
    logic               vrf_rd_req;
    logic [4:0]         vrf_rd_addr;
    logic [VLEN-1:0]    vrf_rd_data = '0;
    logic               vrf_wr_valid;
    logic               vrf_wr_ready = 1'b0;
    logic [4:0]         vrf_wr_addr;
    logic [VLEN-1:0]    vrf_wr_data;
    logic               busy;

    int checks = 0;
    int errors = 0;

    logic [VLEN-1:0] vrf_mem [32];

    logic            mon_en = 1'b0;
    logic            exp_ready, exp_busy, exp_rd_req, exp_wr_valid;
    logic [4:0]      exp_rd_addr, exp_wr_addr;
    logic [VLEN-1:0] exp_wr_data;

    rvv_backend_retire_vd_merge #(.AGNOSTIC_ONES(1'b1)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .rob_valid        (rob_valid),
        .rob_ready        (rob_ready),
        .rob_vd_index     (rob_vd_index),
        .rob_vd_data      (rob_vd_data),
        .rob_vd_byte_type (rob_vd_byte_type),
        .rob_vta          (rob_vta),
        .rob_vma          (rob_vma),
        .rob_trap_flush   (rob_trap_flush),
        .vrf_rd_req       (vrf_rd_req),
        .vrf_rd_addr      (vrf_rd_addr),
        .vrf_rd_data      (vrf_rd_data),
        .vrf_wr_valid     (vrf_wr_valid),
        .vrf_wr_ready     (vrf_wr_ready),
        .vrf_wr_addr      (vrf_wr_addr),
        .vrf_wr_data      (vrf_wr_data),
        .busy             (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [VLEN-1:0] rand_vec();
        logic [VLEN-1:0] v;
        v = '0;
        for (int i = 0; i < VLEN/32; i++) v[32*i +: 32] = $urandom;
        return v;
    endfunction

    // VRF model: old vd returned exactly one cycle after the request, noise otherwise.
    always @(posedge clk) begin
        if (vrf_rd_req) vrf_rd_data <= vrf_mem[vrf_rd_addr];
        else            vrf_rd_data <= rand_vec();
    end

    task automatic check(input string name, input logic [VLEN-1:0] act, input logic [VLEN-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Byte-level reference: what the register must hold after the uop retires.
    function automatic logic [VLEN-1:0] model_merge(input logic [2*VLENB-1:0] bt,
                                                    input logic vta, input logic vma,
                                                    input logic [VLEN-1:0] nd,
                                                    input logic [VLEN-1:0] od,
                                                    output logic need_old, output logic all_keep);
        logic [VLEN-1:0] r;
        logic [1:0]      t;
        r = '0;
        need_old = 1'b0;
        all_keep = 1'b1;
        for (int i = 0; i < VLENB; i++) begin
            t = bt[2*i +: 2];
            if (t == BODY_ACTIVE) begin
                r[8*i +: 8] = nd[8*i +: 8];
                all_keep = 1'b0;
            end else if ((t == TAIL && vta) || (t == BODY_INACTIVE && vma)) begin
                r[8*i +: 8] = 8'hFF;
                all_keep = 1'b0;
            end else begin
                r[8*i +: 8] = od[8*i +: 8];
                need_old = 1'b1;
            end
        end
        return r;
    endfunction

    task automatic set_idle_exp();
        exp_ready    = 1'b1;
        exp_busy     = 1'b0;
        exp_rd_req   = 1'b0;
        exp_wr_valid = 1'b0;
    endtask

    task automatic set_busy_exp(input logic rd, input logic wr);
        exp_ready    = 1'b0;
        exp_busy     = 1'b1;
        exp_rd_req   = rd;
        exp_wr_valid = wr;
    endtask

    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (mon_en) begin
                check("rob_ready", VLEN'(rob_ready), VLEN'(exp_ready));
                check("busy", VLEN'(busy), VLEN'(exp_busy));
                check("vrf_rd_req", VLEN'(vrf_rd_req), VLEN'(exp_rd_req));
                check("vrf_wr_valid", VLEN'(vrf_wr_valid), VLEN'(exp_wr_valid));
                if (exp_rd_req) check("vrf_rd_addr", VLEN'(vrf_rd_addr), VLEN'(exp_rd_addr));
                if (exp_wr_valid) begin
                    check("vrf_wr_addr", VLEN'(vrf_wr_addr), VLEN'(exp_wr_addr));
                    check("vrf_wr_data", vrf_wr_data, exp_wr_data);
                end
            end
        end
    end

    // flush_phase: 0 = flush in RD_OLD, 1 = flush in WAIT_OLD, 2 = random flush during WRITE, other = none.
    task automatic run_uop(input logic [2*VLENB-1:0] bt, input logic vta, input logic vma,
                           input logic [VLEN-1:0] data, input logic [4:0] vd,
                           input bit idle_flush, input int flush_phase, input int stall);
        logic [VLEN-1:0] exp_d;
        logic            nold, akeep;
        exp_d = model_merge(bt, vta, vma, data, vrf_mem[vd], nold, akeep);
        if (idle_flush) begin
            @(negedge clk);
            rob_valid = 1'b1; rob_vd_index = vd; rob_vd_data = data; rob_vd_byte_type = bt;
            rob_vta = vta; rob_vma = vma; rob_trap_flush = 1'b1; vrf_wr_ready = 1'($urandom);
            set_idle_exp();
            exp_ready = 1'b0;
        end
        @(negedge clk);
        rob_valid = 1'b1; rob_vd_index = vd; rob_vd_data = data; rob_vd_byte_type = bt;
        rob_vta = vta; rob_vma = vma; rob_trap_flush = 1'b0; vrf_wr_ready = 1'($urandom);
        set_idle_exp();
        @(negedge clk);
        rob_valid = 1'($urandom); rob_vd_data = rand_vec(); rob_vd_index = 5'($urandom);
        rob_vd_byte_type = '0; vrf_wr_ready = 1'($urandom);
        if (akeep) begin
            rob_valid = 1'b0;
            set_idle_exp();
            return;
        end
        if (nold) begin
            set_busy_exp(1'b1, 1'b0);
            exp_rd_addr = vd;
            rob_trap_flush = (flush_phase == 0);
            if (flush_phase == 0) begin
                @(negedge clk);
                rob_trap_flush = 1'b0; rob_valid = 1'b0;
                set_idle_exp();
                return;
            end
            @(negedge clk);
            set_busy_exp(1'b0, 1'b0);
            rob_trap_flush = (flush_phase == 1);
            if (flush_phase == 1) begin
                @(negedge clk);
                rob_trap_flush = 1'b0; rob_valid = 1'b0;
                set_idle_exp();
                return;
            end
            @(negedge clk);
        end
        for (int k = 0; k <= stall; k++) begin
            if (k > 0) @(negedge clk);
            vrf_wr_ready   = (k == stall);
            rob_trap_flush = (flush_phase == 2) ? 1'($urandom) : 1'b0;
            rob_valid      = 1'($urandom);
            set_busy_exp(1'b0, 1'b1);
            exp_wr_addr = vd;
            exp_wr_data = exp_d;
        end
        vrf_mem[vd] = exp_d;
    endtask

    function automatic logic [2*VLENB-1:0] all_type(input logic [1:0] t);
        logic [2*VLENB-1:0] v;
        for (int i = 0; i < VLENB; i++) v[2*i +: 2] = t;
        return v;
    endfunction

    initial begin
        logic [VLEN-1:0]    d_ramp, d_11, pin;
        logic [2*VLENB-1:0] bt_half;
        logic               nold, akeep;

        for (int i = 0; i < 32; i++) vrf_mem[i] = rand_vec();
        for (int i = 0; i < VLENB; i++) d_ramp[8*i +: 8] = 8'(i);
        d_11 = {VLENB{8'h11}};
        bt_half = all_type(2'(TAIL));
        for (int i = 0; i < VLENB/2; i++) bt_half[2*i +: 2] = 2'(BODY_ACTIVE);

        // Model pins against hand-computed values.
        pin = model_merge(all_type(2'(BODY_ACTIVE)), 1'b0, 1'b0, d_ramp, '0, nold, akeep);
        check("pin_all_active", pin, 128'h0F0E0D0C0B0A09080706050403020100);
        check("pin_all_active_need_old", VLEN'(nold), '0);
        pin = model_merge(bt_half, 1'b1, 1'b0, d_11, '0, nold, akeep);
        check("pin_tail_agn", pin, 128'hFFFFFFFFFFFFFFFF1111111111111111);
        pin = model_merge(bt_half, 1'b0, 1'b0, d_11, {VLENB{8'hAA}}, nold, akeep);
        check("pin_tail_undist", pin, 128'hAAAAAAAAAAAAAAAA1111111111111111);
        check("pin_tail_undist_need_old", VLEN'(nold), VLEN'(1'b1));
        pin = model_merge(all_type(2'(NOT_CHANGE)), 1'b1, 1'b1, d_11, '0, nold, akeep);
        check("pin_all_keep", VLEN'(akeep), VLEN'(1'b1));

        // Reset values.
        #12;
        check("rst_rob_ready", VLEN'(rob_ready), VLEN'(1'b1));
        check("rst_busy", VLEN'(busy), '0);
        check("rst_vrf_rd_req", VLEN'(vrf_rd_req), '0);
        check("rst_vrf_wr_valid", VLEN'(vrf_wr_valid), '0);
        check("rst_vrf_rd_addr", VLEN'(vrf_rd_addr), '0);
        check("rst_vrf_wr_addr", VLEN'(vrf_wr_addr), '0);
        check("rst_vrf_wr_data", vrf_wr_data, '0);
        @(negedge clk);
        rst_n = 1'b1;
        set_idle_exp();
        mon_en = 1'b1;

        // Directed cases.
        run_uop(all_type(2'(BODY_ACTIVE)), 1'b0, 1'b0, d_ramp, 5'd3, 1'b0, 9, 0);
        run_uop(bt_half, 1'b1, 1'b0, d_11, 5'd4, 1'b0, 9, 0);
        vrf_mem[5] = {VLENB{8'hAA}};
        run_uop(bt_half, 1'b0, 1'b0, d_11, 5'd5, 1'b0, 9, 0);
        check("vrf5_after_rmw", vrf_mem[5], 128'hAAAAAAAAAAAAAAAA1111111111111111);
        run_uop(all_type(2'(NOT_CHANGE)), 1'b0, 1'b0, d_11, 5'd6, 1'b0, 9, 0);
        run_uop(all_type(2'(BODY_ACTIVE)), 1'b0, 1'b0, d_ramp, 5'd3, 1'b0, 9, 3);
        vrf_mem[5] = {VLENB{8'hAA}};
        run_uop(bt_half, 1'b0, 1'b0, d_11, 5'd5, 1'b0, 1, 0);
        run_uop(bt_half, 1'b0, 1'b0, d_11, 5'd7, 1'b1, 0, 0);
        run_uop(bt_half, 1'b0, 1'b1, rand_vec(), 5'd8, 1'b0, 2, 2);

        // Randomized uops.
        for (int n = 0; n < 400; n++) begin
            logic [2*VLENB-1:0] bt;
            int mode;
            mode = $urandom_range(0, 9);
            for (int i = 0; i < VLENB; i++) bt[2*i +: 2] = 2'($urandom);
            if (mode == 0) bt = all_type(2'(BODY_ACTIVE));
            if (mode == 1) bt = all_type(2'(NOT_CHANGE));
            run_uop(bt, 1'($urandom), 1'($urandom), rand_vec(), 5'($urandom),
                    ($urandom_range(0, 7) == 0), $urandom_range(0, 5),
                    ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0);
        end

        // Reset while a write is pending.
        @(negedge clk);
        rob_valid = 1'b1; rob_vd_index = 5'd9; rob_vd_data = d_ramp; rob_trap_flush = 1'b0;
        rob_vd_byte_type = all_type(2'(BODY_ACTIVE)); vrf_wr_ready = 1'b0;
        set_idle_exp();
        @(negedge clk);
        rob_valid = 1'b0;
        set_busy_exp(1'b0, 1'b1);
        exp_wr_addr = 5'd9;
        exp_wr_data = d_ramp;
        #4;
        mon_en = 1'b0;
        rst_n = 1'b0;
        #1;
        check("arst_vrf_wr_valid", VLEN'(vrf_wr_valid), '0);
        check("arst_rob_ready", VLEN'(rob_ready), VLEN'(1'b1));
        check("arst_busy", VLEN'(busy), '0);
        check("arst_vrf_rd_req", VLEN'(vrf_rd_req), '0);
        check("arst_vrf_wr_addr", VLEN'(vrf_wr_addr), '0);
        check("arst_vrf_rd_addr", VLEN'(vrf_rd_addr), '0);
        check("arst_vrf_wr_data", vrf_wr_data, '0);
        @(negedge clk);
        rst_n = 1'b1;
        set_idle_exp();
        mon_en = 1'b1;
        run_uop(all_type(2'(BODY_ACTIVE)), 1'b0, 1'b0, d_11, 5'd10, 1'b0, 9, 0);
        @(negedge clk);
        rob_valid = 1'b0;
        set_idle_exp();
        @(negedge clk);
        #3;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
